// File: rtl/sfifo_pkg.sv
// Shared definitions for the FIFO word reader: byte width, default packing
// factor and the two-state FSM encoding.
package sfifo_pkg;

    localparam int BYTE_W                 = 8;
    localparam int DEFAULT_BYTES_PER_WORD = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : sfifo_pkg

// File: rtl/sfifo_lane_pack.sv
// Lane register for the word reader: writes each incoming byte into the next
// free lane and counts how many lanes hold data. last_o flags the write that
// fills the final lane so the FSM can raise word_valid on that same edge.
module sfifo_lane_pack
    import sfifo_pkg::*;
#(
    parameter int LANES  = DEFAULT_BYTES_PER_WORD,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_en_i,
    input  logic                      clr_i,
    input  logic [BYTE_W-1:0]         din_i,
    output logic [LANES*BYTE_W-1:0]   word_o,
    output logic [CNT_W-1:0]          captured_o,
    output logic                      last_o
);

    logic [LANES*BYTE_W-1:0] word_q;
    logic [CNT_W-1:0]        captured_q;

    // Lane write / clear; clear wins, although the FSM never asserts both.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            word_q     <= '0;
            captured_q <= '0;
        end else if (clr_i) begin
            word_q     <= '0;
            captured_q <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (captured_q == CNT_W'(i)) begin
                    word_q[i*BYTE_W +: BYTE_W] <= din_i;
                end
            end
            captured_q <= captured_q + CNT_W'(1);
        end
    end

    assign word_o     = word_q;
    assign captured_o = captured_q;
    assign last_o     = wr_en_i && (captured_q == CNT_W'(LANES - 1));

endmodule : sfifo_lane_pack

// File: rtl/sfifo_word_reader.sv
// Consumer-side controller for the 8-bit synchronous FIFO. Pops bytes while
// the FIFO is non-empty, absorbs the one-cycle registered read latency via
// rd_d1_q, packs BYTES_PER_WORD bytes (first byte in bits [7:0]) and offers
// the word on a valid/ready stream.
//
// Handshake: word_valid rises only in HOLD and stays high with word_data
// stable until an edge where word_valid && word_ready; that edge transfers
// the word and returns to FILL. word_ready with word_valid low is ignored.
//
// Optional build macro SFIFO_RD_FLUSH_EN adds a flush input (emit a partial
// word once in-flight reads land) and a word_keep lane mask output.
module sfifo_word_reader
    import sfifo_pkg::*;
#(
    parameter int  BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      fifo_empty,
    input  logic [BYTE_W-1:0]         fifo_data,
    output logic                      fifo_rd,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [WORD_W-1:0]         word_data,
    output logic                      busy,
    output logic                      dbg_state
`ifdef SFIFO_RD_FLUSH_EN
    ,
    input  logic                      flush,
    output logic [BYTES_PER_WORD-1:0] word_keep
`endif
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    state_e           state_q;
    logic [CNT_W-1:0] issued_q;
    logic             rd_d1_q;
    logic             word_valid_q;
    logic [CNT_W-1:0] captured;
    logic             lane_last;
    logic             accept;
    logic             rd_en;
`ifdef SFIFO_RD_FLUSH_EN
    logic             flush_pend_q;
    logic [BYTES_PER_WORD-1:0] keep_d;
`endif

    // Pop strobe: only in FILL, never on an empty FIFO, never past a full word.
    always_comb begin
        rd_en = (state_q == FILL) && !fifo_empty &&
                (issued_q < CNT_W'(BYTES_PER_WORD));
`ifdef SFIFO_RD_FLUSH_EN
        if (flush_pend_q) begin
            rd_en = 1'b0;
        end
`endif
    end

    assign fifo_rd = rd_en;
    assign accept  = (state_q == HOLD) && word_ready;

    sfifo_lane_pack #(
        .LANES (BYTES_PER_WORD)
    ) u_lane_pack (
        .clk_i      (CLK),
        .rstn_i     (RSTn),
        .wr_en_i    (rd_d1_q),
        .clr_i      (accept),
        .din_i      (fifo_data),
        .word_o     (word_data),
        .captured_o (captured),
        .last_o     (lane_last)
    );

    // Pop/handshake FSM with its registered outputs and issue counter.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= FILL;
            issued_q     <= '0;
            rd_d1_q      <= 1'b0;
            word_valid_q <= 1'b0;
`ifdef SFIFO_RD_FLUSH_EN
            flush_pend_q <= 1'b0;
`endif
        end else begin
            rd_d1_q <= rd_en;
            case (state_q)
                FILL: begin
                    if (rd_en) begin
                        issued_q <= issued_q + CNT_W'(1);
                    end
                    if (lane_last) begin
                        word_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
`ifdef SFIFO_RD_FLUSH_EN
                    else if (flush_pend_q && !rd_d1_q) begin
                        // Pops are blocked, so nothing is left in flight here.
                        if (captured != '0) begin
                            word_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end else begin
                            flush_pend_q <= 1'b0;
                        end
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        issued_q     <= '0;
                        state_q      <= FILL;
`ifdef SFIFO_RD_FLUSH_EN
                        flush_pend_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

`ifdef SFIFO_RD_FLUSH_EN
    // Lane mask: lanes below the capture count hold data.
    always_comb begin
        keep_d = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            keep_d[i] = (CNT_W'(i) < captured);
        end
    end

    assign word_keep = keep_d;
`endif

    assign word_valid = word_valid_q;
    assign busy       = (state_q == HOLD) || (issued_q != '0) || rd_d1_q ||
                        (captured != '0);
    assign dbg_state  = state_q;

endmodule : sfifo_word_reader

// File: doc/sfifo_word_reader.md
Name: sfifo_word_reader

Overview:
- Consumer-side controller for the 8-bit synchronous FIFO.
- Pops bytes from the FIFO read port and packs BYTES_PER_WORD of them into one word.
- Presents each word on a valid/ready output stream to downstream logic (wishbone-facing register or LA capture).
- Owns all FIFO read timing: it never pops an empty FIFO and accounts for the FIFO's registered one-cycle read latency.

Parameters:
- BYTES_PER_WORD, 4: bytes packed per output word; legal range 2..8.
- WORD_W, 8*BYTES_PER_WORD: output word width; derived, not overridable.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RSTn  input  1  synchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid in the cycle after fifo_rd was high.
- fifo_rd  output  1  FIFO pop strobe; one byte per high cycle.
- word_valid  output  1  packed word available.
- word_ready  input  1  downstream accepts the word; transfer occurs when word_valid && word_ready at an edge.
- word_data  output  WORD_W  packed word; byte 0 (first popped) in bits [7:0].
- busy  output  1  high when any byte is in flight or held; low only in FILL with zero bytes issued.

Behaviour:
- Reset: synchronous; RSTn low at an edge sets the following:
  - state = FILL;
  - fifo_rd = 0, word_valid = 0, word_data = 0, busy = 0;
  - issued = 0, captured = 0, rd_d1 = 0.
- Reset overrides every other input. A read in flight when reset is applied is discarded and not captured after reset.
- Counters:
  - issued counts bytes popped in the current word.
  - captured counts bytes written into word_data.
  - Both are clog2(BYTES_PER_WORD+1) bits wide.
- fifo_rd is combinational: fifo_rd = (state==FILL) && !fifo_empty && (issued < BYTES_PER_WORD).
  - Back-to-back pops are allowed.
  - fifo_rd is never high while fifo_empty is high.
- rd_d1 is a register and equals fifo_rd delayed by one cycle.
- On an edge where rd_d1 = 1:
  - fifo_data is written into lane `captured`, i.e. bits [8*captured+7 : 8*captured];
  - captured increments.
- State FILL:
  - issued increments on each edge where fifo_rd = 1.
  - When the capture edge fills the last lane (captured becomes BYTES_PER_WORD), on that same edge: word_valid <= 1, state <= HOLD.
- State HOLD:
  - fifo_rd = 0; word_data and word_valid are held stable.
  - On an edge with word_ready = 1: word_valid <= 0, issued <= 0, captured <= 0, word_data <= 0, state <= FILL.
  - Popping may restart in the cycle after acceptance; there is no pop overlap with HOLD.
- Latency with a non-empty FIFO and BYTES_PER_WORD=4:
  - fifo_rd high in cycles 0..3;
  - word_valid high from cycle 5;
  - after acceptance, next fifo_rd in the following cycle.
- FIFO empty mid-word: pops stall and resume when fifo_empty falls; partial lanes are retained indefinitely.
- word_ready while word_valid = 0: ignored.
- word_ready held high continuously: one word is accepted per HOLD visit; no double accept.

Optional Feature:
- Macro SFIFO_RD_FLUSH_EN.
- When defined, two ports are added:
  - flush  input  1;
  - word_keep  output  BYTES_PER_WORD: lane valid mask, bit i = lane i holds data.
- flush sampled high in FILL sets flush_pend, which blocks further pops.
- Once rd_d1 = 0 and captured > 0:
  - word_valid <= 1, state <= HOLD;
  - word_keep = (1<<captured)-1; unused lanes read as 0.
- If captured = 0 and nothing is in flight, flush_pend clears with no output.
- flush_pend clears on word acceptance and on reset.
- A full word always has word_keep all-ones.
- flush in HOLD is ignored.
- When the macro is undefined: no flush or word_keep ports, and only full words are emitted.

Decomposition:
- Package sfifo_pkg holds:
  - BYTE_W = 8;
  - DEFAULT_BYTES_PER_WORD = 4;
  - state encoding (FILL = 1'b0, HOLD = 1'b1).
- A sub-module sfifo_lane_pack is natural: the lane register plus captured counter, with a lane-write enable in, and word_data and full flag out.
- The pop/handshake FSM stays in the top module.

Test Plan:
- Preload FIFO with 0x11, 0x22, 0x33, 0x44 and hold word_ready = 1:
  - fifo_rd high in cycles 0..3;
  - word_valid high in cycle 5 with word_data = 0x44332211;
  - accepted at the end of cycle 5.
- Preload 8 bytes 0x01..0x08 and hold word_ready = 0 for 10 cycles:
  - first word = 0x04030201, held stable;
  - fifo_rd stays 0 throughout HOLD;
  - after ready, second word = 0x08070605.
- Empty-FIFO guard: push 2 bytes (0xAA, 0xBB) and wait 20 cycles:
  - fifo_rd never high while fifo_empty = 1; word_valid stays 0;
  - push 0xCC, 0xDD → word 0xDDCCBBAA.
- Reset mid-word: assert RSTn = 0 after 2 captures plus 1 in flight:
  - next cycle all outputs and counters are 0;
  - subsequent 4 bytes 0x5A..0x5D → 0x5D5C5B5A.
- SFIFO_RD_FLUSH_EN: capture 3 bytes 0x10, 0x20, 0x30, then pulse flush:
  - word_data = 0x00302010, word_keep = 4'b0111;
  - flush with 0 bytes produces no word.
